// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection sequencer: controller state encoding,
// default dwell counts and the approach reset-state values used by light_state_machine.
package intersection_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP_FLASH = 3'd0,
        ST_RELEASE       = 3'd1,
        ST_RUN           = 3'd2,
        ST_FAULT         = 3'd3
    } ctrl_state_e;

    localparam logic [31:0] DEF_STARTUP_FLASH_TICKS   = 32'd250000000;
    localparam logic [31:0] DEF_RESET_PULSE_TICKS     = 32'd2;
    localparam logic [31:0] DEF_CONFLICT_FILTER_TICKS = 32'd4;
    localparam logic [31:0] DEF_WATCHDOG_TICKS        = 32'd3000000000;

    localparam logic RESET_TO_RED             = 1'b0;
    localparam logic RESET_TO_GREEN_LEFT_TURN = 1'b1;

    // A tick count of zero behaves as one.
    function automatic logic [31:0] ticks_min1(input logic [31:0] t);
        return (t == 32'd0) ? 32'd1 : t;
    endfunction

endpackage

// File: rtl/conflict_monitor.sv
// Turns sustained crossing right-of-way into a one-cycle conflict_fault pulse.
// INTERSECTION_WATCHDOG_EN adds a no-activity watchdog sharing the same pulse.
module conflict_monitor
    import intersection_pkg::*;
#(
    parameter logic [31:0] FILTER_TICKS   = DEF_CONFLICT_FILTER_TICKS,
    parameter logic [31:0] WATCHDOG_TICKS = DEF_WATCHDOG_TICKS
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_enable,
    input  logic in_ns_green,
    input  logic in_ns_yellow,
    input  logic in_ns_left,
    input  logic in_ew_green,
    input  logic in_ew_yellow,
    input  logic in_ew_left,
    output logic conflict_fault
);

    localparam logic [31:0] FILTER_LIM = ticks_min1(FILTER_TICKS);

    logic        conflict;
    logic        filter_hit;
    logic        wd_hit;
    logic [31:0] filter_q, filter_d;
    logic        fault_q, fault_d;

    assign conflict = (in_ns_green | in_ns_yellow | in_ns_left) &
                      (in_ew_green | in_ew_yellow | in_ew_left);

`ifdef INTERSECTION_WATCHDOG_EN
    localparam logic [31:0] WD_LIM = ticks_min1(WATCHDOG_TICKS);

    logic [5:0]  mon_now, mon_prev_q;
    logic [31:0] wd_q, wd_d;

    assign mon_now = {in_ns_green, in_ns_yellow, in_ns_left,
                      in_ew_green, in_ew_yellow, in_ew_left};

    always_comb begin
        wd_d   = '0;
        wd_hit = 1'b0;
        if (in_enable && (mon_now == mon_prev_q)) begin
            wd_d = wd_q + 32'd1;
            if (wd_d >= WD_LIM) begin
                wd_hit = 1'b1;
                wd_d   = '0;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        mon_prev_q <= mon_now;
        if (in_reset) wd_q <= '0;
        else          wd_q <= wd_d;
    end
`else
    logic [31:0] unused_wd_ticks;
    assign unused_wd_ticks = WATCHDOG_TICKS;
    assign wd_hit          = 1'b0;
`endif

    // Counter restarts after a hit so the pulse stays one cycle wide.
    always_comb begin
        filter_d   = '0;
        filter_hit = 1'b0;
        if (in_enable && conflict) begin
            filter_d = filter_q + 32'd1;
            if (filter_d >= FILTER_LIM) begin
                filter_hit = 1'b1;
                filter_d   = '0;
            end
        end
        fault_d = filter_hit | wd_hit;
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            filter_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            filter_q <= filter_d;
            fault_q  <= fault_d;
        end
    end

    assign conflict_fault = fault_q;

endmodule

// File: rtl/intersection_controller.sv
// Start-up, release and fault sequencer for the NS/EW approaches.
// Define INTERSECTION_WATCHDOG_EN to enable the no-activity watchdog in RUN.
module intersection_controller
    import intersection_pkg::*;
#(
    parameter logic [31:0] STARTUP_FLASH_TICKS   = DEF_STARTUP_FLASH_TICKS,
    parameter logic [31:0] RESET_PULSE_TICKS     = DEF_RESET_PULSE_TICKS,
    parameter logic [31:0] CONFLICT_FILTER_TICKS = DEF_CONFLICT_FILTER_TICKS,
    parameter logic [31:0] WATCHDOG_TICKS        = DEF_WATCHDOG_TICKS
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_fault_clear,
    input  logic       in_ns_green,
    input  logic       in_ns_yellow,
    input  logic       in_ns_left,
    input  logic       in_ew_green,
    input  logic       in_ew_yellow,
    input  logic       in_ew_left,
    output logic       out_ns_reset,
    output logic       out_ew_reset,
    output logic       out_ns_reset_state,
    output logic       out_ew_reset_state,
    output logic       out_issue,
    output logic       out_fault,
    output logic [7:0] out_fault_count,
    output logic [2:0] out_state
);

    localparam logic [31:0] STARTUP_LAST = ticks_min1(STARTUP_FLASH_TICKS) - 32'd1;
    localparam logic [31:0] PULSE_LAST   = ticks_min1(RESET_PULSE_TICKS) - 32'd1;

    ctrl_state_e state_q, state_d;
    logic [31:0] dwell_q, dwell_d;
    logic        issue_q, issue_d;
    logic        release_q, release_d;
    logic        fault_q, fault_d;
    logic [7:0]  fault_count_q, fault_count_d;
    logic        conflict_fault;

    conflict_monitor #(
        .FILTER_TICKS   (CONFLICT_FILTER_TICKS),
        .WATCHDOG_TICKS (WATCHDOG_TICKS)
    ) u_monitor (
        .in_clock       (in_clock),
        .in_reset       (in_reset),
        .in_enable      (state_q == ST_RUN),
        .in_ns_green    (in_ns_green),
        .in_ns_yellow   (in_ns_yellow),
        .in_ns_left     (in_ns_left),
        .in_ew_green    (in_ew_green),
        .in_ew_yellow   (in_ew_yellow),
        .in_ew_left     (in_ew_left),
        .conflict_fault (conflict_fault)
    );

    // Dwell counts elapsed cycles in the current state; it is zero on every state entry.
    always_comb begin
        state_d = state_q;
        dwell_d = '0;
        case (state_q)
            ST_STARTUP_FLASH: begin
                dwell_d = dwell_q + 32'd1;
                if (dwell_q >= STARTUP_LAST) begin
                    state_d = ST_RELEASE;
                    dwell_d = '0;
                end
            end
            ST_RELEASE: begin
                dwell_d = dwell_q + 32'd1;
                if (dwell_q >= PULSE_LAST) begin
                    state_d = ST_RUN;
                    dwell_d = '0;
                end
            end
            ST_RUN:   if (conflict_fault) state_d = ST_FAULT;
            ST_FAULT: if (in_fault_clear) state_d = ST_STARTUP_FLASH;
            default:  state_d = ST_STARTUP_FLASH;
        endcase

        fault_count_d = fault_count_q;
        if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (fault_count_q != 8'hFF))
            fault_count_d = fault_count_q + 8'd1;

        issue_d   = (state_d == ST_STARTUP_FLASH) || (state_d == ST_FAULT);
        release_d = (state_d == ST_RELEASE);
        fault_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q       <= ST_STARTUP_FLASH;
            dwell_q       <= '0;
            issue_q       <= 1'b1;
            release_q     <= 1'b0;
            fault_q       <= 1'b0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            issue_q       <= issue_d;
            release_q     <= release_d;
            fault_q       <= fault_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign out_ns_reset       = release_q;
    assign out_ew_reset       = release_q;
    assign out_ns_reset_state = RESET_TO_GREEN_LEFT_TURN;
    assign out_ew_reset_state = RESET_TO_RED;
    assign out_issue          = issue_q;
    assign out_fault          = fault_q;
    assign out_fault_count    = fault_count_q;
    assign out_state          = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Randomized bench for intersection_controller against a cycle-level behavioural model.
module tb_intersection_controller;

    localparam int T_STARTUP = 10;
    localparam int T_PULSE   = 2;
    localparam int T_FILTER  = 4;
    localparam int T_WD      = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr;
    logic       ns_g, ns_y, ns_l, ew_g, ew_y, ew_l;
    logic       out_ns_reset, out_ew_reset, out_ns_reset_state, out_ew_reset_state;
    logic       out_issue, out_fault;
    logic [7:0] out_fault_count;
    logic [2:0] out_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [5:0] mon;

    intersection_controller #(
        .STARTUP_FLASH_TICKS   (32'(T_STARTUP)),
        .RESET_PULSE_TICKS     (32'(T_PULSE)),
        .CONFLICT_FILTER_TICKS (32'(T_FILTER)),
        .WATCHDOG_TICKS        (32'(T_WD))
    ) dut (
        .in_clock           (clk),
        .in_reset           (rst),
        .in_fault_clear     (clr),
        .in_ns_green        (ns_g),
        .in_ns_yellow       (ns_y),
        .in_ns_left         (ns_l),
        .in_ew_green        (ew_g),
        .in_ew_yellow       (ew_y),
        .in_ew_left         (ew_l),
        .out_ns_reset       (out_ns_reset),
        .out_ew_reset       (out_ew_reset),
        .out_ns_reset_state (out_ns_reset_state),
        .out_ew_reset_state (out_ew_reset_state),
        .out_issue          (out_issue),
        .out_fault          (out_fault),
        .out_fault_count    (out_fault_count),
        .out_state          (out_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state uses the published state numbers; m_elapsed is cycles already spent there.
    int   m_state = 0, m_elapsed = 0, m_run = 0, m_stable = 0, m_count = 0;
    bit   m_pending = 1'b0;
    logic [5:0] m_prev = '0;

    task automatic model_step();
        logic [5:0] cur;
        int nxt;
        bit conf;
        cur  = {ns_g, ns_y, ns_l, ew_g, ew_y, ew_l};
        conf = (|cur[5:3]) && (|cur[2:0]);
        if (rst) begin
            m_state = 0; m_elapsed = 0; m_run = 0; m_stable = 0;
            m_pending = 1'b0; m_count = 0; m_prev = cur;
            return;
        end
        nxt = m_state;
        case (m_state)
            0: if (m_elapsed + 1 >= T_STARTUP) nxt = 1;
            1: if (m_elapsed + 1 >= T_PULSE) nxt = 2;
            2: begin
                if (m_pending) nxt = 3;
                else begin
                    m_run = conf ? m_run + 1 : 0;
                    if (m_run >= T_FILTER) begin m_pending = 1'b1; m_run = 0; end
`ifdef INTERSECTION_WATCHDOG_EN
                    m_stable = (cur == m_prev) ? m_stable + 1 : 0;
                    if (m_stable >= T_WD) begin m_pending = 1'b1; m_stable = 0; end
`endif
                end
            end
            default: if (clr) nxt = 0;
        endcase
        if (nxt == 3 && m_state != 3 && m_count < 255) m_count++;
        m_elapsed = (nxt == m_state) ? m_elapsed + 1 : 0;
        if (nxt != 2) begin m_run = 0; m_stable = 0; m_pending = 1'b0; end
        m_state = nxt;
        m_prev  = cur;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, half a cycle after the edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("state",     32'(out_state), 32'(m_state));
            chk("issue",     32'(out_issue), 32'(m_state == 0 || m_state == 3));
            chk("ns_reset",  32'(out_ns_reset), 32'(m_state == 1));
            chk("ew_reset",  32'(out_ew_reset), 32'(m_state == 1));
            chk("fault",     32'(out_fault), 32'(m_state == 3));
            chk("count",     32'(out_fault_count), 32'(m_count));
            chk("ns_rstate", 32'(out_ns_reset_state), 32'd1);
            chk("ew_rstate", 32'(out_ew_reset_state), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_mon(input logic [5:0] m);
        {ns_g, ns_y, ns_l, ew_g, ew_y, ew_l} = m;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string name);
        int n = 0;
        while (out_state !== s && n < lim) begin
            step(1);
            n++;
        end
        checks++;
        if (out_state !== s) begin
            errors++;
            $display("FAIL %s timeout: state %0d expected %0d", name, out_state, s);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; mon = '0;
        set_mon(6'b000000);
        step(3);
        chk_en = 1'b1;
        chk("rst_state", 32'(out_state), 32'd0);
        chk("rst_issue", 32'(out_issue), 32'd1);
        chk("rst_count", 32'(out_fault_count), 32'd0);

        // Reset release: 10 cycles flashing, 2 cycles release pulse, then RUN.
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("rel_issue", 32'(out_issue), 32'(i < 10));
            chk("rel_resets", 32'({out_ns_reset, out_ew_reset}), (i == 10 || i == 11) ? 32'd3 : 32'd0);
            chk("rel_state", 32'(out_state), (i < 10) ? 32'd0 : ((i < 12) ? 32'd1 : 32'd2));
            step(1);
        end

        // Conflict one cycle short of the filter: no fault.
        set_mon(6'b100001);
        step(3);
        set_mon(6'b000000);
        step(8);
        chk("short_fault", 32'(out_fault), 32'd0);
        chk("short_state", 32'(out_state), 32'd2);

        // Full-length conflict: fault appears five cycles after it starts.
        set_mon(6'b100001);
        step(4);
        chk("pre_fault", 32'(out_fault), 32'd0);
        set_mon(6'b000000);
        step(1);
        chk("fault_hit", 32'(out_fault), 32'd1);
        chk("fault_issue", 32'(out_issue), 32'd1);
        chk("fault_count1", 32'(out_fault_count), 32'd1);

        // FAULT holds without a clear, then restarts from STARTUP_FLASH.
        step(100);
        chk("fault_hold", 32'(out_state), 32'd3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_state", 32'(out_state), 32'd0);
        chk("clr_fault", 32'(out_fault), 32'd0);
        chk("clr_count", 32'(out_fault_count), 32'd1);

        // Reset during RELEASE.
        wait_state(3'd1, 30, "wait_release");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_resets", 32'({out_ns_reset, out_ew_reset}), 32'd0);
        chk("mid_issue", 32'(out_issue), 32'd1);
        chk("mid_count", 32'(out_fault_count), 32'd0);

        // Quiet monitors in RUN.
        wait_state(3'd2, 40, "wait_run_wd");
        step(55);
`ifdef INTERSECTION_WATCHDOG_EN
        chk("wd_state", 32'(out_state), 32'd3);
`else
        chk("wd_state", 32'(out_state), 32'd2);
`endif
        clr = 1'b1;
        step(1);
        clr = 1'b0;

        // Randomized traffic, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mon = 6'($urandom);
                if ($urandom_range(0, 1) == 0) mon[2:0] = 3'b000;
            end
            set_mon(mon);
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 1'b0; clr = 1'b0;
        set_mon(6'b000000);

        // Saturation: 256 faults from a clean count.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int k = 0; k < 256; k++) begin
            wait_state(3'd2, 40, "sat_run");
            set_mon(6'b010010);
            wait_state(3'd3, 20, "sat_fault");
            set_mon(6'b000000);
            clr = 1'b1;
            step(1);
            clr = 1'b0;
        end
        chk("sat_count", 32'(out_fault_count), 32'd255);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
